pool_row_packer: RTL and testbench

- Downstream consumer of the max-pool stage. Captures each pooled byte (data_out qualified by valid_op) and packs four bytes into a 32-bit word.
- Packed words are buffered in a small first-word-fall-through (FWFT) FIFO and presented on a valid/ready stream to the writeback/DMA stage.
- end_op from the pooler closes the current row/frame: any partial word is flushed and the stream packet is tagged last.

---
 rtl/pool_row_packer.sv | 146 ++++++++++++++
 tb/tb_pool_row_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_row_packer.sv
// Packs pooled bytes into 32-bit words and queues them in a FWFT FIFO on a valid/ready stream.
// Optional POOL_PACKER_STATS_EN adds word_count (words popped) and drop_count (words dropped) ports.
module pool_row_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                          clk,
  input  logic                          master_rst,
  input  logic                          ce,
  input  logic [7:0]                    pool_data,
  input  logic                          pool_valid,
  input  logic                          pool_end,
  output logic [31:0]                   m_data,
  output logic [3:0]                    m_keep,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef POOL_PACKER_STATS_EN
  ,
  output logic [15:0]                   word_count,
  output logic [7:0]                    drop_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  word_t          mem [FIFO_DEPTH];
  logic [1:0]     byte_idx;
  logic [31:0]    asm_q;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           take;
  logic           flush;
  logic           push;
  logic           pop;
  logic           full;
  logic           wr_en;
  logic           drop;
  word_t          push_word;

  always_comb begin
    take  = ce & pool_valid;
    flush = ce & pool_end;
    push  = (take && byte_idx == 2'd3) || flush;

    // Assembly register already holds PAD_BYTE in unfilled lanes, so only the incoming byte is merged.
    push_word.data = asm_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (take && byte_idx == 2'(i)) begin
        push_word.data[8*i +: 8] = pool_data;
      end
    end

    unique case ({take, byte_idx})
      3'b100:  push_word.keep = 4'b0001;
      3'b101:  push_word.keep = 4'b0011;
      3'b110:  push_word.keep = 4'b0111;
      3'b111:  push_word.keep = 4'b1111;
      3'b000:  push_word.keep = 4'b0000;
      3'b001:  push_word.keep = 4'b0001;
      3'b010:  push_word.keep = 4'b0011;
      default: push_word.keep = 4'b0111;
    endcase
    push_word.last = flush;
  end

  always_ff @(posedge clk) begin
    if (!master_rst) begin
      byte_idx <= '0;
      asm_q    <= {4{PAD_BYTE}};
    end else if (push) begin
      byte_idx <= '0;
      asm_q    <= {4{PAD_BYTE}};
    end else if (take) begin
      byte_idx <= byte_idx + 2'd1;
      asm_q    <= push_word.data;
    end
  end

  always_comb begin
    full    = (level == FULL_LEVEL);
    m_valid = (level != '0);
    pop     = m_valid & m_ready;
    wr_en   = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (!master_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_comb begin
    fifo_level = level;
    if (m_valid) begin
      m_data = mem[rd_ptr].data;
      m_keep = mem[rd_ptr].keep;
      m_last = mem[rd_ptr].last;
    end else begin
      m_data = '0;
      m_keep = '0;
      m_last = 1'b0;
    end
  end

`ifdef POOL_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!master_rst) begin
      word_count <= '0;
      drop_count <= '0;
    end else begin
      if (pop) word_count <= word_count + 16'd1;
      if (drop && drop_count != '1) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_row_packer.sv
// Randomized and directed bench for pool_row_packer against a queue-based packing model.
module tb_pool_row_packer;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  PAD   = 8'h00;

  logic        clk = 1'b0;
  logic        master_rst;
  logic        ce;
  logic [7:0]  pool_data;
  logic        pool_valid;
  logic        pool_end;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;
`ifdef POOL_PACKER_STATS_EN
  logic [15:0] word_count;
  logic [7:0]  drop_count;
`endif

  always #5 clk = ~clk;

  pool_row_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .ce         (ce),
    .pool_data  (pool_data),
    .pool_valid (pool_valid),
    .pool_end   (pool_end),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef POOL_PACKER_STATS_EN
    ,
    .word_count (word_count),
    .drop_count (drop_count)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t       mq[$];
  logic [7:0]  part[$];
  bit          m_ovf;
  int unsigned m_wc;
  int unsigned m_dc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: collect bytes in a list; a word closes when four bytes are held or on end.
  task automatic model_step();
    bit    do_pop, take, flush, accept;
    word_t w;
    if (!master_rst) begin
      mq.delete();
      part.delete();
      m_ovf = 0;
      m_wc  = 0;
      m_dc  = 0;
      return;
    end
    do_pop = (mq.size() > 0) && m_ready;
    take   = ce && pool_valid;
    flush  = ce && pool_end;
    accept = 0;
    if (take) part.push_back(pool_data);
    if ((take && part.size() == 4) || flush) begin
      w.d = {4{PAD}};
      for (int i = 0; i < part.size(); i++) w.d[8*i +: 8] = part[i];
      w.k = 4'((1 << part.size()) - 1);
      w.l = flush;
      part.delete();
      if (mq.size() == DEPTH && !do_pop) begin
        m_ovf = 1;
        if (m_dc < 255) m_dc++;
      end else begin
        accept = 1;
      end
    end
    if (do_pop) begin
      void'(mq.pop_front());
      m_wc = (m_wc + 1) % 65536;
    end
    if (accept) mq.push_back(w);
  endtask

  task automatic compare_all();
    check_val("m_valid", m_valid, mq.size() != 0);
    check_val("fifo_level", fifo_level, mq.size());
    check_val("overflow", overflow, m_ovf);
    if (mq.size() != 0) begin
      check_val("m_data", m_data, mq[0].d);
      check_val("m_keep", m_keep, mq[0].k);
      check_val("m_last", m_last, mq[0].l);
    end
`ifdef POOL_PACKER_STATS_EN
    check_val("word_count", word_count, m_wc);
    check_val("drop_count", drop_count, m_dc);
`endif
  endtask

  task automatic step(input logic c, input logic v, input logic [7:0] d,
                      input logic e, input logic r, input logic rs);
    ce = c; pool_valid = v; pool_data = d; pool_end = e; m_ready = r; master_rst = rs;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic feed(input logic [7:0] d, input logic e, input logic r);
    step(1'b1, 1'b1, d, e, r, 1'b1);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 8'h00, 1'b0, r, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ce = 0; pool_valid = 0; pool_data = 0; pool_end = 0; m_ready = 0; master_rst = 0;
    model_step();
    @(posedge clk);
    do_reset();
    check_val("rst_m_data", m_data, 32'h0);
    check_val("rst_m_keep", m_keep, 4'h0);
    check_val("rst_m_last", m_last, 1'b0);

    // Full word, one-cycle visibility
    feed(8'h11, 0, 1); feed(8'h22, 0, 1); feed(8'h33, 0, 1);
    check_val("pre_word_valid", m_valid, 1'b0);
    feed(8'h44, 0, 1);
    check_val("word_valid", m_valid, 1'b1);
    check_val("word_data", m_data, 32'h44332211);
    check_val("word_keep", m_keep, 4'b1111);
    check_val("word_last", m_last, 1'b0);
    idle(1);

    // Partial flushes
    feed(8'hAA, 0, 1); feed(8'hBB, 0, 1);
    step(1, 0, 8'h00, 1, 1, 1);
    check_val("flush2_data", m_data, 32'h0000BBAA);
    check_val("flush2_keep", m_keep, 4'b0011);
    check_val("flush2_last", m_last, 1'b1);
    idle(1);
    feed(8'hAA, 0, 1); feed(8'hBB, 0, 1); feed(8'hCC, 1, 1);
    check_val("flush3_data", m_data, 32'h00CCBBAA);
    check_val("flush3_keep", m_keep, 4'b0111);
    check_val("flush3_last", m_last, 1'b1);
    idle(1);
    step(1, 0, 8'h00, 1, 1, 1);
    check_val("empty_mark_valid", m_valid, 1'b1);
    check_val("empty_mark_data", m_data, 32'h0);
    check_val("empty_mark_keep", m_keep, 4'b0000);
    check_val("empty_mark_last", m_last, 1'b1);
    idle(1);

    // Overflow: 10 words into an 8-deep FIFO
    for (int k = 0; k < 40; k++) begin
      feed(8'(k), 0, 0);
      if (k == 31) check_val("ovf_before_9th", overflow, 1'b0);
    end
    check_val("ovf_level", fifo_level, 4'd8);
    check_val("ovf_set", overflow, 1'b1);
    check_val("ovf_head", m_data, 32'h03020100);
    for (int k = 0; k < 8; k++) idle(1);
    check_val("ovf_drained", m_valid, 1'b0);
    check_val("ovf_sticky", overflow, 1'b1);

    // Push with simultaneous pop on a full FIFO; ce=0 bytes ignored
    do_reset();
    for (int k = 0; k < 35; k++) feed(8'(k + 8'h40), 0, 0);
    step(0, 1, 8'hEE, 0, 0, 1);
    feed(8'h99, 0, 1);
    check_val("full_pop_level", fifo_level, 4'd8);
    check_val("full_pop_ovf", overflow, 1'b0);
    for (int k = 0; k < 9; k++) idle(1);

    // Reset mid-packet with queued words
    for (int k = 0; k < 14; k++) feed(8'(k + 8'h80), 0, 0);
    do_reset();
    check_val("midrst_valid", m_valid, 1'b0);
    check_val("midrst_level", fifo_level, 4'd0);
    check_val("midrst_ovf", overflow, 1'b0);
    feed(8'h01, 0, 0); feed(8'h02, 0, 0); feed(8'h03, 0, 0); feed(8'h04, 0, 0);
    check_val("fresh_data", m_data, 32'h04030201);
    check_val("fresh_keep", m_keep, 4'b1111);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0), 8'($urandom),
           1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 299) != 0));
    end
    for (int n = 0; n < DEPTH + 2; n++) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
